// File: rtl/seq_signed_multiplier.sv
// -----------------------------------------------------------------------------
// seq_signed_multiplier
//
// Iterative shift-and-add multiplier for NO_BITS x NO_BITS operands with a
// 2*NO_BITS product. Signed (two's complement) or unsigned operation is chosen
// per transaction. The operand magnitudes are multiplied, and the sign is
// applied in a single FIX cycle at the end.
//
// Timing: operands are accepted on an IDLE edge with in_valid=1. The block then
// spends NO_BITS cycles in MUL and one cycle in FIX. out_valid rises after
// edge t0+NO_BITS+1 and holds until out_ready=1.
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous, active-high reset
//   in_valid     operands present on x / y / is_signed
//   in_ready     block can accept operands (IDLE only)
//   is_signed    1 = two's complement operands, 0 = unsigned
//   x, y         multiplicand, multiplier (NO_BITS each)
//   out_valid    product available (DONE state)
//   out_ready    consumer takes product
//   out_product  2*NO_BITS product
//   busy         high in any state other than IDLE
// -----------------------------------------------------------------------------
module seq_signed_multiplier #(
  parameter int NO_BITS = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   is_signed,
  input  logic [NO_BITS-1:0]     x,
  input  logic [NO_BITS-1:0]     y,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [2*NO_BITS-1:0]   out_product,
  output logic                   busy
);

  localparam int PW    = 2 * NO_BITS;
  localparam int CNT_W = (NO_BITS > 1) ? $clog2(NO_BITS) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic               mode_q, mode_d;
  logic               neg_q, neg_d;
  logic [NO_BITS-1:0] mag_x_q, mag_x_d;
  logic [NO_BITS-1:0] mag_y_q, mag_y_d;
  logic [PW-1:0]      acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [PW-1:0]      prod_q, prod_d;

  // Sign-magnitude conversion of the incoming operands. Negating the most
  // negative value gives the same bit pattern, which read as an unsigned
  // magnitude is exactly 2^(N-1), so no extra bit is needed.
  logic               x_neg, y_neg;
  logic [NO_BITS-1:0] x_mag, y_mag;

  always_comb begin
    x_neg = is_signed & x[NO_BITS-1];
    y_neg = is_signed & y[NO_BITS-1];
    x_mag = x_neg ? -x : x;
    y_mag = y_neg ? -y : y;
  end

  // NOTE: every signal assigned in this block gets a default first, so no
  // path through the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    neg_d   = neg_q;
    mag_x_d = mag_x_q;
    mag_y_d = mag_y_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    prod_d  = prod_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          mode_d  = is_signed;
          mag_x_d = x_mag;
          mag_y_d = y_mag;
          neg_d   = x_neg ^ y_neg;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = MUL;
        end
      end

      MUL: begin
        // One partial product per cycle. No short-circuit for zero operands,
        // so the latency stays fixed.
        if (mag_y_q[cnt_q]) begin
          acc_d = acc_q + (PW'(mag_x_q) << cnt_q);
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(NO_BITS - 1)) begin
          state_d = FIX;
        end
      end

      FIX: begin
        // -0 is 0 in two's complement, so a zero product never becomes negative.
        prod_d  = neg_q ? -acc_q : acc_q;
        state_d = DONE;
      end

      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update
  // together from values sampled before the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      mode_q  <= 1'b0;
      neg_q   <= 1'b0;
      mag_x_q <= '0;
      mag_y_q <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      prod_q  <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      neg_q   <= neg_d;
      mag_x_q <= mag_x_d;
      mag_y_q <= mag_y_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      prod_q  <= prod_d;
    end
  end

  // The mode flag is kept so the transaction type can be read in a waveform.
  // The sign is already folded into neg_q, so no logic reads mode_q.
  logic unused_mode;
  assign unused_mode = mode_q;

  assign in_ready    = (state_q == IDLE);
  assign out_valid   = (state_q == DONE);
  assign busy        = (state_q != IDLE);
  assign out_product = prod_q;

endmodule

// File: tb/tb_seq_signed_multiplier.sv
// -----------------------------------------------------------------------------
// tb_seq_signed_multiplier
//
// Directed bench for seq_signed_multiplier at NO_BITS=5. Expected products are
// pushed into a scoreboard queue when the operands are driven. They are popped
// and compared when the DUT presents out_valid.
// -----------------------------------------------------------------------------
module tb_seq_signed_multiplier;

  localparam int N  = 5;
  localparam int W  = 2 * N;
  localparam int TO = 60;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic         is_signed;
  logic [N-1:0] x;
  logic [N-1:0] y;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_product;
  logic         busy;

  int checks   = 0;
  int failures = 0;

  logic [W-1:0] sb_q[$];

  seq_signed_multiplier #(.NO_BITS(N)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .is_signed   (is_signed),
    .x           (x),
    .y           (y),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_product (out_product),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference product, built from sign- or zero-extended 32-bit operands.
  function automatic logic [W-1:0] model(input logic s, input logic [N-1:0] a,
                                         input logic [N-1:0] b);
    logic [31:0] ia, ib, p;
    ia = s ? {{(32-N){a[N-1]}}, a} : {{(32-N){1'b0}}, a};
    ib = s ? {{(32-N){b[N-1]}}, b} : {{(32-N){1'b0}}, b};
    p  = ia * ib;
    return p[W-1:0];
  endfunction

  // Drive one operand pair when in_ready is high and push the expected value.
  // The task returns #1 after the accepting edge.
  task automatic send(input logic s, input logic [N-1:0] a, input logic [N-1:0] b,
                      input logic [W-1:0] exp);
    int k = 0;
    @(negedge clk);
    while (!in_ready && k < TO) begin
      @(negedge clk);
      k++;
    end
    if (k >= TO) check("in_ready_timeout", 32'd0, 32'd1);
    in_valid  = 1'b1;
    is_signed = s;
    x         = a;
    y         = b;
    sb_q.push_back(exp);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    x        = N'($urandom);
    y        = N'($urandom);
  endtask

  // Count edges from acceptance to out_valid. When wiggle=1, operands and
  // in_valid are scrambled while the multiply runs.
  task automatic wait_result(input string tag, input logic wiggle);
    int lat = 0;
    while (lat < TO) begin
      @(posedge clk);
      lat++;
      #1;
      if (out_valid) break;
      if (wiggle) begin
        x         = N'($urandom);
        y         = N'($urandom);
        is_signed = 1'($urandom);
        in_valid  = 1'($urandom);
      end
    end
    in_valid = 1'b0;
    check({tag, "_latency"}, 32'(lat), 32'(N + 1));
  endtask

  // Hold out_ready low for 'hold' cycles, then compare against the scoreboard
  // and take the product.
  task automatic receive(input string tag, input int hold);
    logic [W-1:0] exp;
    logic [W-1:0] first;
    if (sb_q.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd0, 32'd1);
      exp = '0;
    end else begin
      exp = sb_q.pop_front();
    end
    first = out_product;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
      check({tag, "_hold_prod"}, 32'(out_product), 32'(first));
      check({tag, "_hold_in_ready"}, 32'(in_ready), 32'd0);
    end
    @(negedge clk);
    check({tag, "_product"}, 32'(out_product), 32'(exp));
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    check({tag, "_released"}, {30'd0, out_valid, in_ready}, 32'b01);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    is_signed = 1'b0;
    x         = '0;
    y         = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state.
    @(negedge clk);
    check("reset_in_ready", 32'(in_ready), 32'd1);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_product", 32'(out_product), 32'd0);

    // (-16) x (-16) = 256: largest positive product.
    send(1'b1, 5'h10, 5'h10, 10'h100);
    wait_result("neg16sq", 1'b0);
    receive("neg16sq", 0);

    // -3 x 7 and 7 x -3 = -21.
    send(1'b1, 5'h1D, 5'h07, 10'h3EB);
    wait_result("m3x7", 1'b0);
    receive("m3x7", 0);
    send(1'b1, 5'h07, 5'h1D, 10'h3EB);
    wait_result("7xm3", 1'b0);
    receive("7xm3", 0);

    // Same bits, two modes: 31*31 unsigned, (-1)*(-1) signed.
    send(1'b0, 5'h1F, 5'h1F, 10'h3C1);
    wait_result("u31x31", 1'b0);
    receive("u31x31", 0);
    send(1'b1, 5'h1F, 5'h1F, 10'h001);
    wait_result("sm1xm1", 1'b0);
    receive("sm1xm1", 0);

    // Zero times negative: no negative zero, same latency.
    send(1'b1, 5'h00, 5'h10, 10'h000);
    wait_result("zero", 1'b0);
    receive("zero", 0);

    // Back-pressure for 5 cycles with operands scrambled during MUL.
    send(1'b1, 5'h0B, 5'h1A, model(1'b1, 5'h0B, 5'h1A));
    wait_result("bp", 1'b1);
    receive("bp", 5);

    // Next transaction is accepted right after release.
    send(1'b0, 5'h13, 5'h06, model(1'b0, 5'h13, 5'h06));
    wait_result("after_bp", 1'b0);
    receive("after_bp", 0);

    // Random operands in both modes.
    for (int i = 0; i < 6; i++) begin
      logic         s;
      logic [N-1:0] a, b;
      s = 1'($urandom);
      a = N'($urandom);
      b = N'($urandom);
      send(s, a, b, model(s, a, b));
      wait_result("rand", 1'b0);
      receive("rand", i % 2);
    end

    // Reset mid-multiply at cnt=2 drops the transaction.
    send(1'b1, 5'h05, 5'h05, 10'h019);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    void'(sb_q.pop_back());
    @(negedge clk);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_product", 32'(out_product), 32'd0);

    // 9 x (-2) = -18.
    send(1'b1, 5'h09, 5'h1E, 10'h3EE);
    wait_result("9xm2", 1'b0);
    receive("9xm2", 0);

    check("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
